// File: rtl/spi_rx_defs.sv
// Shared definitions for the SPI block receiver: FSM states, start token and
// the CRC16-CCITT polynomial with its bit-serial step.
package spi_rx_defs;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_RECV,
    ST_CRC
  } rx_state_t;

  localparam logic [7:0]  SPI_START_TOKEN = 8'hFE;
  localparam logic [15:0] SPI_CRC16_POLY  = 16'h1021;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? SPI_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/spi_crc16.sv
// Bit-serial CRC16-CCITT (init 0x0000) over the received data bits.
module spi_crc16
  import spi_rx_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (bit_en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/spi_block_receiver.sv
// SPI MISO multi-word receiver with first-low-bit or 0xFE-token start and hunt timeout.
// Define SPI_RX_CRC16_EN to check the trailing CRC16 in token mode.
module spi_block_receiver
  import spi_rx_defs::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned MAX_WORDS     = 512,
  parameter int unsigned TIMEOUT_EDGES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sclk_posedge,
  input  logic                           in,
  input  logic                           start,
  input  logic                           mode,
  input  logic [$clog2(MAX_WORDS+1)-1:0] num_words,
  output logic [DATA_BITS-1:0]           out_data,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic                           crc_err
);

  localparam int unsigned NW = $clog2(MAX_WORDS + 1);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned TW = $clog2(TIMEOUT_EDGES + 1);

  rx_state_t            state, state_next;
  logic                 mode_r;
  logic [NW-1:0]        words_r, word_cnt, words_clamped;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [7:0]           tok, tok_next;
  logic [TW-1:0]        edge_cnt;
  logic [3:0]           crc_cnt;
  logic                 accept, hunt_hit, hunt_expire, word_end, last_word, crc_end;

  always_comb begin
    state_next    = state;
    shift_next    = {shift[DATA_BITS-2:0], in};
    tok_next      = {tok[6:0], in};
    accept        = (state == ST_IDLE) && start && !done;
    hunt_hit      = mode_r ? (tok_next == SPI_START_TOKEN) : !in;
    hunt_expire   = (edge_cnt == TW'(TIMEOUT_EDGES - 1));
    word_end      = (bit_cnt == BW'(DATA_BITS - 1));
    last_word     = ((word_cnt + NW'(1)) == words_r);
    crc_end       = (crc_cnt == 4'd15);
    words_clamped = num_words;
    if (num_words == '0)
      words_clamped = NW'(1);
    else if (num_words > NW'(MAX_WORDS))
      words_clamped = NW'(MAX_WORDS);

    case (state)
      ST_IDLE: if (accept) state_next = ST_HUNT;
      ST_HUNT: begin
        // A start pattern on the final allowed edge wins over the timeout.
        if (sclk_posedge && hunt_hit)
          state_next = ST_RECV;
        else if (sclk_posedge && hunt_expire)
          state_next = ST_IDLE;
      end
      ST_RECV: if (sclk_posedge && word_end && last_word)
        state_next = mode_r ? ST_CRC : ST_IDLE;
      ST_CRC:  if (sclk_posedge && crc_end) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r    <= 1'b0;
      words_r   <= '0;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tok       <= '0;
      edge_cnt  <= '0;
      crc_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          mode_r   <= mode;
          words_r  <= words_clamped;
          word_cnt <= '0;
          bit_cnt  <= '0;
          tok      <= '0;
          edge_cnt <= '0;
          crc_cnt  <= '0;
          timeout  <= 1'b0;
        end
        ST_HUNT: if (sclk_posedge) begin
          edge_cnt <= edge_cnt + TW'(1);
          tok      <= tok_next;
          if (hunt_hit) begin
            if (!mode_r) begin
              shift   <= {{(DATA_BITS-1){1'b0}}, in};
              bit_cnt <= BW'(1);
            end else begin
              bit_cnt <= '0;
            end
          end else if (hunt_expire) begin
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_RECV: if (sclk_posedge) begin
          shift <= shift_next;
          if (word_end) begin
            bit_cnt   <= '0;
            out_data  <= shift_next;
            out_valid <= 1'b1;
            word_cnt  <= word_cnt + NW'(1);
            if (last_word && !mode_r) done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_CRC: if (sclk_posedge) begin
          crc_cnt <= crc_cnt + 4'd1;
          if (crc_end) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_RX_CRC16_EN
  logic [15:0] crc_calc, crc_rx;

  spi_crc16 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .bit_en (sclk_posedge && (state == ST_RECV) && mode_r),
    .bit_in (in),
    .crc    (crc_calc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_rx  <= '0;
      crc_err <= 1'b0;
    end else if (accept) begin
      crc_err <= 1'b0;
    end else if ((state == ST_CRC) && sclk_posedge) begin
      crc_rx <= {crc_rx[14:0], in};
      if (crc_end) crc_err <= ({crc_rx[14:0], in} != crc_calc);
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_block_receiver.sv
// Scoreboard bench for spi_block_receiver: expected words queued as sent,
// checked when out_valid strobes; a second instance exercises the hunt timeout.
module tb_spi_block_receiver;

  logic       clk = 1'b0;
  logic       reset, sclk_posedge, miso, start, start2, mode;
  logic [9:0] num_words;
  logic [7:0] out_data, out_data2;
  logic       out_valid, busy, done, timeout, crc_err;
  logic       out_valid2, busy2, done2, timeout2, crc_err2;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_done   = 0;
  int n_valid2 = 0;
  logic d_valid, d_busy, d_timeout, d_crc_err;
  logic [7:0] sb[$];

`ifdef SPI_RX_CRC16_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_block_receiver #(.DATA_BITS(8), .MAX_WORDS(512), .TIMEOUT_EDGES(4096)) dut (
    .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .in(miso),
    .start(start), .mode(mode), .num_words(num_words),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
    .timeout(timeout), .crc_err(crc_err)
  );

  spi_block_receiver #(.DATA_BITS(8), .MAX_WORDS(512), .TIMEOUT_EDGES(16)) dut_to (
    .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .in(miso),
    .start(start2), .mode(mode), .num_words(num_words),
    .out_data(out_data2), .out_valid(out_valid2), .busy(busy2), .done(done2),
    .timeout(timeout2), .crc_err(crc_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      n_valid++;
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                check("word", {24'd0, out_data}, {24'd0, sb.pop_front()});
    end
    if (done) begin
      n_done++;
      d_valid   = out_valid;
      d_busy    = busy;
      d_timeout = timeout;
      d_crc_err = crc_err;
    end
    if (out_valid2) n_valid2++;
  end

  // All tasks start and end at posedge+1.
  task automatic send_bit(input logic b);
    miso = b; sclk_posedge = 1'b1;
    @(posedge clk); #1;
    sclk_posedge = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_xfer(input logic m, input logic [9:0] n);
    mode = m; num_words = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && n_done < target; i++) begin
      @(posedge clk); #1;
    end
    check("done_seen", n_done, target);
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic sector(input logic flip);
    logic [15:0] crc;
    logic [7:0]  b;
    int v0, d0;
    crc = 16'h0000;
    v0 = n_valid; d0 = n_done;
    start_xfer(1'b1, 10'd512);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    send_byte(8'hFE);
    for (int i = 0; i < 512; i++) begin
      b = i[7:0];
      sb.push_back(b);
      for (int k = 7; k >= 0; k--) crc = crc_model(crc, b[k]);
      send_byte(b);
    end
    crc[0] = crc[0] ^ flip;
    for (int k = 15; k >= 0; k--) send_bit(crc[k]);
    wait_done(d0 + 1);
    check("sec_valid_cnt", n_valid - v0, 512);
    check("sec_done_no_valid", d_valid, 1'b0);
    check("sec_done_busy", d_busy, 1'b0);
    check("sec_crc_err", d_crc_err, flip & CRC_ON);
    check("sec_sb_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("sec_crc_sticky", crc_err, flip & CRC_ON);
  endtask

  initial begin
    int v0, d0;
    reset = 1'b1; sclk_posedge = 1'b0; miso = 1'b1;
    start = 1'b0; start2 = 1'b0; mode = 1'b0; num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_crc_err", crc_err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single R1 response after idle-high bits
    v0 = n_valid; d0 = n_done;
    start_xfer(1'b0, 10'd1);
    check("busy_after_start", busy, 1);
    repeat (5) send_bit(1'b1);
    sb.push_back(8'h01);
    send_byte(8'h01);
    wait_done(d0 + 1);
    check("r1_valid_cnt", n_valid - v0, 1);
    check("r1_done_with_valid", d_valid, 1);
    check("r1_done_busy", d_busy, 0);
    check("r1_timeout", d_timeout, 0);

    // R7 multi-word response
    v0 = n_valid; d0 = n_done;
    start_xfer(1'b0, 10'd5);
    send_bit(1'b1);
    foreach (sb[i]) check("sb_pre_empty", 1, 0);
    begin
      logic [7:0] r7 [5];
      r7 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
      foreach (r7[i]) begin
        sb.push_back(r7[i]);
        send_byte(r7[i]);
      end
    end
    wait_done(d0 + 1);
    check("r7_valid_cnt", n_valid - v0, 5);
    check("r7_done_with_valid", d_valid, 1);
    check("r7_done_busy", d_busy, 0);

    // Sector reads: good CRC, then CRC LSB flipped
    sector(1'b0);
    sector(1'b1);
    start_xfer(1'b0, 10'd1);
    check("crc_err_cleared", crc_err, 0);
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    wait_done(n_done > 0 ? n_done : 1);

    // Hunt timeout on the 16-edge instance
    start2 = 1'b1; mode = 1'b0; num_words = 10'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (15) send_bit(1'b1);
    check("to_not_yet", done2, 0);
    check("to_busy_hunt", busy2, 1);
    miso = 1'b1; sclk_posedge = 1'b1;
    @(posedge clk); #1;
    sclk_posedge = 1'b0;
    check("to_done", done2, 1);
    check("to_timeout", timeout2, 1);
    check("to_busy_fall", busy2, 0);
    check("to_crc_err", crc_err2, 0);
    @(posedge clk); #1;
    check("to_done_pulse", done2, 0);
    check("to_sticky", timeout2, 1);
    check("to_no_valid", n_valid2, 0);
    check("to_data", out_data2, 0);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("to_cleared", timeout2, 0);

    // Reset after 3 bits of word 2
    v0 = n_valid;
    start_xfer(1'b0, 10'd5);
    sb.push_back(8'h01); send_byte(8'h01);
    sb.push_back(8'h22); send_byte(8'h22);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("mid_data", out_data, 8'h22);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_data", out_data, 0);
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_timeout", timeout, 0);
    check("mr_crc_err", crc_err, 0);
    reset = 1'b0;
    check("mr_valid_cnt", n_valid - v0, 2);
    check("mr_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Fresh transfer with num_words=0 (one word); start while busy is ignored
    v0 = n_valid; d0 = n_done;
    start_xfer(1'b0, 10'd0);
    send_bit(1'b1); send_bit(1'b1);
    start_xfer(1'b1, 10'd5);
    sb.push_back(8'h5A);
    send_byte(8'h5A);
    wait_done(d0 + 1);
    check("re_valid_cnt", n_valid - v0, 1);
    check("re_done_with_valid", d_valid, 1);
    check("re_busy", busy, 0);
    check("re_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_block_receiver.md
# spi_block_receiver

Parametrised SPI MISO receiver for the SD card reader. It generalises the single-byte response receiver to multi-word transfers. It supports two start modes: the first low bit (R1/R3/R7 responses) or the 0xFE data start token (512-byte sector reads). It streams each completed word out with a one-cycle valid strobe and applies a hunt timeout. It sits between the SD controller FSM and the SCLK edge generator and shares the generator's `sclk_posedge` strobe.

## Interface
- `DATA_BITS`, 8: bits per output word, ≥ 2
- `MAX_WORDS`, 512: largest transfer in words
- `TIMEOUT_EDGES`, 4096: `sclk_posedge` strobes allowed in HUNT before giving up
- `clk` in 1: system clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `sclk_posedge` in 1: one-`clk` strobe; MISO is sampled only when this is high
- `in` in 1: MISO
- `start` in 1: one-cycle request; ignored while `busy`
- `mode` in 1: 0 = first-low-bit start, 1 = 0xFE token start plus 16-bit CRC; latched on `start`
- `num_words` in $clog2(MAX_WORDS+1): words to receive; latched on `start`; 0 is treated as 1; values above MAX_WORDS are clamped
- `out_data` out DATA_BITS: last completed word, MSB first on the wire
- `out_valid` out 1: one-cycle strobe per completed word
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle strobe at the end of a transfer, or on timeout
- `timeout` out 1: sticky until the next accepted `start`
- `crc_err` out 1: sticky until the next accepted `start`

## Operation
- States: IDLE, HUNT, RECV, CRC.
- **IDLE:** `start` is accepted here. On acceptance the block latches `mode` and `num_words`, clears the counters, `timeout` and `crc_err`, and goes to HUNT. `busy` rises the next cycle.
- **HUNT, mode 0:** on a `sclk_posedge` with `in`=0, that bit is stored as bit DATA_BITS-1 of word 0 and the bit counter is set to 1. The block then goes to RECV.
- **HUNT, mode 1:** an 8-bit shift register holds the sampled bits. When it equals 0xFE after a `sclk_posedge`, the block goes to RECV with the bit counter at 0. The token is not output.
- **HUNT, timeout:** each `sclk_posedge` in HUNT increments the edge counter. On reaching TIMEOUT_EDGES the block sets `timeout`, pulses `done`, and returns to IDLE. No `out_valid` is issued.
- **RECV:** on each `sclk_posedge` the block does `shift = {shift[DATA_BITS-2:0], in}`. On the DATA_BITS-th bit it loads `out_data`, pulses `out_valid`, increments the word counter and wraps the bit counter to 0. After word `num_words`:
  - mode 0 → IDLE with `done`.
  - mode 1 → CRC.
- **CRC:** the next 16 sampled bits are the received CRC, MSB first. After the 16th bit, `crc_err` = (received ≠ computed) and `done` pulses. The block then returns to IDLE.
- **Reset:** `reset` at any point forces IDLE and clears all outputs and counters. A partial word is discarded.
- **Outputs at reset:** `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `timeout`=0, `crc_err`=0.

## Timing
- `out_valid` is high exactly one `clk` after the `clk` carrying the `sclk_posedge` that sampled the word's last bit. `out_data` holds that word until the next word completes.
- mode 0: the final `out_valid`, `done` and `busy` falling occur in the same cycle.
- mode 1: `done` occurs one `clk` after the 16th CRC bit. `crc_err` is valid in the `done` cycle.
- Timeout: `done` and `timeout` assert one `clk` after the TIMEOUT_EDGES-th strobe.
- A `start` coincident with `done` is ignored. A new `start` is accepted from the cycle after `done`.
- A `sclk_posedge` in the same cycle as an accepted `start` is not sampled.

## Configuration
- `SPI_RX_CRC16_EN` defined:
  - a bit-serial CRC16-CCITT (poly 0x1021, init 0x0000) runs over every data bit in mode 1;
  - the result is compared in the CRC state.
- Undefined:
  - the 16 CRC bits are still clocked in and discarded, with identical timing;
  - `crc_err` is tied to 0;
  - no CRC logic is synthesised.

## Structure
- Shared package/include `spi_rx_defs`:
  - state encodings;
  - `SPI_START_TOKEN` = 8'hFE;
  - `SPI_CRC16_POLY` = 16'h1021.
- Sub-module `spi_crc16`:
  - inputs `clk`, `reset`, `clear`, `bit_en`, `bit_in`;
  - output `crc[15:0]`;
  - instantiated only under `SPI_RX_CRC16_EN`.

## Test plan
- **Mode 0 response:** `num_words`=1, MISO idles high for 5 edges, then 0x01 is sent → one `out_valid` with 0x01, `done` in the same cycle, `timeout`=0.
- **Mode 0 multi-word:** `num_words`=5, R7 bytes 0x01 0x00 0x00 0x01 0xAA → five `out_valid` in order, `done` with the fifth.
- **Mode 1 sector:**
  - Stimulus: `num_words`=512, 0xFF×3, then 0xFE, then bytes i mod 256, then the correct CRC.
  - Expect 512 `out_valid`, the token not output, and `crc_err`=0.
  - Repeat with the CRC LSB flipped → `crc_err`=1 (with `SPI_RX_CRC16_EN`), 0 without.
- **Timeout:** TIMEOUT_EDGES=16 with MISO held high → `done` and `timeout` one cycle after the 16th strobe, no `out_valid`. The next `start` clears `timeout`.
- **Reset mid-transfer and re-start:**
  - `reset` asserted after 3 bits of word 2 → all outputs 0 the next cycle.
  - A fresh mode 0 transfer then completes normally.
  - A `start` while `busy` has no effect.
